// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - datapath-side inputs and display-side outputs of the 7-segment scanner
interface seg7_scan_display_if;
  logic [31:0] PC_Counter;
  logic [31:0] Reg_Write;
  logic        Sel;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        Frame;

  modport master (
    output PC_Counter, Reg_Write, Sel,
    input  An, Seg, Dp, Frame
  );

  modport slave (
    input  PC_Counter, Reg_Write, Sel,
    output An, Seg, Dp, Frame
  );
endinterface

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - per-frame snapshot of PC or write-back data scanned onto 8 hex digits
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input logic              Clk,
  input logic              Reset,
  seg7_scan_display_if.slave bus
);
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic          lit;
  logic          primed;
  logic [31:0]   snap;
  logic          src_pc;

  logic          tick;
  logic          frame_end;
  logic          load;
  logic [2:0]    idx_next;
  logic [31:0]   snap_next;
  logic          src_pc_next;
  logic [3:0]    nib;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // lit stays low until the first tick so that tick shows digit 0 rather than advancing past it
  always_comb begin
    tick        = (div == DIV_LAST);
    frame_end   = tick && lit && (idx == 3'd7);
    load        = !primed || frame_end;
    idx_next    = (tick && lit) ? idx + 3'd1 : idx;
    snap_next   = load ? (bus.Sel ? bus.PC_Counter : bus.Reg_Write) : snap;
    src_pc_next = load ? bus.Sel : src_pc;
    nib         = snap_next[{idx_next, 2'b00} +: 4];
    seg_next    = hex7(nib);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_next != 3'd0) && ((snap_next >> {idx_next, 2'b00}) == 32'd0))
      seg_next = 7'h7F;
`else
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div       <= '0;
      idx       <= 3'd0;
      lit       <= 1'b0;
      primed    <= 1'b0;
      snap      <= 32'd0;
      src_pc    <= 1'b0;
      bus.An    <= 8'hFF;
      bus.Seg   <= 7'h7F;
      bus.Dp    <= 1'b1;
      bus.Frame <= 1'b0;
    end else begin
      div       <= tick ? '0 : div + 1'b1;
      primed    <= 1'b1;
      snap      <= snap_next;
      src_pc    <= src_pc_next;
      bus.Frame <= frame_end;
      if (tick) begin
        lit     <= 1'b1;
        idx     <= idx_next;
        bus.An  <= ~(8'b1 << idx_next);
        bus.Seg <= seg_next;
        bus.Dp  <= !((idx_next == 3'd0) && src_pc_next);
      end
    end
  end
endmodule
